// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode / func3 / func7 encodings and FSM state type
//                for the execute-stage ALU with iterative multiply/divide.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // RV32I major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // func7 selectors
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // integer func3 codes
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // branch func3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // M-extension func3 codes
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iter
//  Description : Iterative multiply (shift-add) / divide (restoring) engine
//                working on operand magnitudes, one step per clock, XLEN
//                steps per operation. Result is presented combinationally
//                on the cycle done is high so it can be captured at that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_abort,
    input  logic            i_start,
    input  logic            i_is_div,
    input  logic            i_op1_signed,
    input  logic            i_op2_signed,
    input  logic            i_sel_hi,      // mul: high half, div: remainder
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] c_LAST = SHW'(XLEN - 1);

    logic              r_run;
    logic [SHW-1:0]    r_cnt;
    logic              r_is_div;
    logic              r_sel_hi;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic [2*XLEN-1:0] r_acc;      // product accumulator
    logic [2*XLEN-1:0] r_mcand;    // multiplicand, shifted left per step
    logic [XLEN-1:0]   r_mplier;   // multiplier (mul) or dividend/quotient (div)
    logic [XLEN-1:0]   r_rem;      // partial remainder
    logic [XLEN-1:0]   r_dvsr;     // divisor magnitude

    logic              w_neg1;
    logic              w_neg2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic              w_fits;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;

    assign w_neg1 = i_op1_signed & i_op1[XLEN-1];
    assign w_neg2 = i_op2_signed & i_op2[XLEN-1];
    assign w_mag1 = w_neg1 ? -i_op1 : i_op1;
    assign w_mag2 = w_neg2 ? -i_op2 : i_op2;

    // One shift-add step and one restoring-divide step
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_rem_sh  = {r_rem, r_mplier[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvsr};
    assign w_fits    = ~w_diff[XLEN];
    assign w_rem_nxt = w_fits ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_nxt = {r_mplier[XLEN-2:0], w_fits};

    // Re-apply signs to the magnitude results of the final step
    assign w_prod_s = r_neg_res ? -w_acc_nxt : w_acc_nxt;
    assign w_quo_s  = r_neg_res ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_s  = r_neg_rem ? -w_rem_nxt : w_rem_nxt;

    assign o_done   = r_run && (r_cnt == c_LAST);
    assign o_result = r_is_div ? (r_sel_hi ? w_rem_s : w_quo_s)
                               : (r_sel_hi ? w_prod_s[2*XLEN-1:XLEN] : w_prod_s[XLEN-1:0]);

    // Operand latch on start, then one iteration per clock until the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run     <= 1'b0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_sel_hi  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_dvsr    <= '0;
        end else if (i_abort) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_run     <= 1'b1;
            r_cnt     <= '0;
            r_is_div  <= i_is_div;
            r_sel_hi  <= i_sel_hi;
            r_neg_res <= w_neg1 ^ w_neg2;
            r_neg_rem <= w_neg1;
            r_acc     <= '0;
            r_mcand   <= {{XLEN{1'b0}}, w_mag1};
            r_mplier  <= i_is_div ? w_mag1 : w_mag2;
            r_rem     <= '0;
            r_dvsr    <= w_mag2;
        end else if (r_run) begin
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_run <= 1'b0;
            end
            if (r_is_div) begin
                r_rem    <= w_rem_nxt;
                r_mplier <= w_quo_nxt;
            end else begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mdu
//  Description : Handshaked execute-stage ALU. RV32I integer, compare,
//                address and link results in one registered cycle; M-extension
//                multiply/divide through the iterative mdu_iter engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            zero,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_alu_out;
    logic            r_zero;

    logic [XLEN-1:0] w_sc_result;
    logic [XLEN-1:0] w_imm_u;
    logic [SHW-1:0]  w_shamt;
    logic            w_lt;
    logic            w_ltu;
    logic            w_eq;
    logic            w_is_m;
    logic            w_div0;
    logic            w_ovf;
    logic            w_div_special;
    logic            w_accept;
    logic            w_start_mdu;
    logic            w_op1_signed;
    logic            w_op2_signed;
    logic            w_sel_hi;
    logic            w_mdu_done;
    logic [XLEN-1:0] w_mdu_result;

    assign w_imm_u = {operand2[XLEN-1:12], 12'b0};
    assign w_shamt = operand2[SHW-1:0];
    assign w_lt    = $signed(operand1) < $signed(operand2);
    assign w_ltu   = operand1 < operand2;
    assign w_eq    = operand1 == operand2;

    // Divide corner cases are resolved in the single-cycle path
    assign w_is_m        = (opcode == OP_R) && (func7 == F7_MULDIV);
    assign w_div0        = (operand2 == '0);
    assign w_ovf         = !func3[0] && (operand1 == c_SMIN) && (operand2 == '1);
    assign w_div_special = w_is_m && func3[2] && (w_div0 || w_ovf);

    assign in_ready    = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_start_mdu = w_accept && w_is_m && !w_div_special;

    // MUL/MULH/DIV/REM are signed on both operands; MULHSU only on operand1
    assign w_op1_signed = (func3 == F3_MUL) || (func3 == F3_MULH) || (func3 == F3_MULHSU)
                       || (func3 == F3_DIV) || (func3 == F3_REM);
    assign w_op2_signed = (func3 == F3_MUL) || (func3 == F3_MULH)
                       || (func3 == F3_DIV) || (func3 == F3_REM);
    assign w_sel_hi     = func3[2] ? func3[1] : (func3[1:0] != 2'b00);

    mdu_iter #(
        .XLEN (XLEN)
    ) u_mdu_iter (
        .clk          (clk),
        .rst          (rst),
        .i_abort      (flush),
        .i_start      (w_start_mdu),
        .i_is_div     (func3[2]),
        .i_op1_signed (w_op1_signed),
        .i_op2_signed (w_op2_signed),
        .i_sel_hi     (w_sel_hi),
        .i_op1        (operand1),
        .i_op2        (operand2),
        .o_done       (w_mdu_done),
        .o_result     (w_mdu_result)
    );

    // Single-cycle result; every undefined encoding falls through to zero
    always_comb begin
        w_sc_result = '0;
        case (opcode)
            OP_LUI:    w_sc_result = w_imm_u;
            OP_AUIPC:  w_sc_result = operand1 + w_imm_u;
            OP_JAL:    w_sc_result = operand1 + XLEN'(4);
            OP_JALR:   if (func3 == 3'b000) w_sc_result = operand1 + XLEN'(4);
            OP_LOAD:   if ((func3 != 3'b011) && (func3 != 3'b110) && (func3 != 3'b111))
                           w_sc_result = operand1 + operand2;
            OP_STORE:  if (func3[2:1] != 2'b11 && !func3[2])
                           w_sc_result = operand1 + operand2;
            OP_BRANCH: begin
                case (func3)
                    F3_BEQ:  w_sc_result = XLEN'(w_eq);
                    F3_BNE:  w_sc_result = XLEN'(!w_eq);
                    F3_BLT:  w_sc_result = XLEN'(w_lt);
                    F3_BGE:  w_sc_result = XLEN'(!w_lt);
                    F3_BLTU: w_sc_result = XLEN'(w_ltu);
                    F3_BGEU: w_sc_result = XLEN'(!w_ltu);
                    default: w_sc_result = '0;
                endcase
            end
            OP_IMM: begin
                case (func3)
                    F3_ADD:  w_sc_result = operand1 + operand2;
                    F3_SLT:  w_sc_result = XLEN'(w_lt);
                    F3_SLTU: w_sc_result = XLEN'(w_ltu);
                    F3_XOR:  w_sc_result = operand1 ^ operand2;
                    F3_OR:   w_sc_result = operand1 | operand2;
                    F3_AND:  w_sc_result = operand1 & operand2;
                    F3_SLL:  if (func7 == F7_BASE) w_sc_result = operand1 << w_shamt;
                    F3_SR: begin
                        if (func7 == F7_BASE)
                            w_sc_result = operand1 >> w_shamt;
                        else if (func7 == F7_ALT)
                            w_sc_result = $unsigned($signed(operand1) >>> w_shamt);
                    end
                    default: w_sc_result = '0;
                endcase
            end
            OP_R: begin
                if (func7 == F7_BASE) begin
                    case (func3)
                        F3_ADD:  w_sc_result = operand1 + operand2;
                        F3_SLL:  w_sc_result = operand1 << w_shamt;
                        F3_SLT:  w_sc_result = XLEN'(w_lt);
                        F3_SLTU: w_sc_result = XLEN'(w_ltu);
                        F3_XOR:  w_sc_result = operand1 ^ operand2;
                        F3_SR:   w_sc_result = operand1 >> w_shamt;
                        F3_OR:   w_sc_result = operand1 | operand2;
                        F3_AND:  w_sc_result = operand1 & operand2;
                        default: w_sc_result = '0;
                    endcase
                end else if (func7 == F7_ALT) begin
                    if (func3 == F3_ADD)
                        w_sc_result = operand1 - operand2;
                    else if (func3 == F3_SR)
                        w_sc_result = $unsigned($signed(operand1) >>> w_shamt);
                end else if (w_div_special) begin
                    if (w_div0)
                        w_sc_result = func3[1] ? operand1 : '1;
                    else
                        w_sc_result = func3[1] ? '0 : operand1;
                end
            end
            default: w_sc_result = '0;
        endcase
    end

    // Next-state and handshake outputs; flush overrides everything but rst
    always_comb begin
        w_next_state = r_state;
        out_valid    = (r_state == DONE);
        busy         = (r_state == MUL) || (r_state == DIV);
        if (flush) begin
            w_next_state = IDLE;
        end else if (w_accept) begin
            if (w_start_mdu)
                w_next_state = func3[2] ? DIV : MUL;
            else
                w_next_state = DONE;
        end else if ((r_state == DONE) && out_ready) begin
            w_next_state = IDLE;
        end else if (busy && w_mdu_done) begin
            w_next_state = DONE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Result register with zero flag kept in lockstep
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out <= '0;
            r_zero    <= TRUE;
        end else if (!flush) begin
            if (w_accept && !w_start_mdu) begin
                r_alu_out <= w_sc_result;
                r_zero    <= (w_sc_result == '0);
            end else if (busy && w_mdu_done) begin
                r_alu_out <= w_mdu_result;
                r_zero    <= (w_mdu_result == '0);
            end
        end
    end

    assign alu_out = r_alu_out;
    assign zero    = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mdu
//  Description : Directed self-checking bench for alu_mdu, with a 32-bit and
//                a 64-bit instance sharing clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, out_ready;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [31:0] op1, op2, alu_out;
    logic        in_ready, out_valid, zero, busy;

    logic        flush64, in_valid64, out_ready64;
    logic [6:0]  opcode64, func7_64;
    logic [2:0]  func3_64;
    logic [63:0] op1_64, op2_64, alu_out64;
    logic        in_ready64, out_valid64, zero64, busy64;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } sc_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } m_vec_t;

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func3(func3), .func7(func7), .operand1(op1), .operand2(op2),
        .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out), .zero(zero), .busy(busy)
    );

    alu_mdu #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
        .opcode(opcode64), .func3(func3_64), .func7(func7_64), .operand1(op1_64), .operand2(op2_64),
        .out_valid(out_valid64), .out_ready(out_ready64), .alu_out(alu_out64), .zero(zero64), .busy(busy64)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Offer one op for one edge; caller is positioned 1 time unit after an edge
    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        opcode = op; func3 = f3; func7 = f7; op1 = a; op2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drive64(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [63:0] a, input logic [63:0] b);
        opcode64 = op; func3_64 = f3; func7_64 = f7; op1_64 = a; op2_64 = b; in_valid64 = 1'b1;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
    endtask

    // Cycles after accept until out_valid, bounded; flags any non-busy wait cycle
    task automatic wait_out(input int max, output int cyc, output bit stall_bad);
        cyc = 0; stall_bad = 0;
        while (!out_valid && cyc < max) begin
            if (!busy || in_ready) stall_bad = 1;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic wait_out64(input int max, output int cyc);
        cyc = 0;
        while (!out_valid64 && cyc < max) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (alu_out !== 32'h0) begin failures++; $display("FAIL reset_alu_out got=%h exp=0", alu_out); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid64 !== 1'b0 || zero64 !== 1'b1) begin failures++; $display("FAIL reset64 out_valid=%b zero=%b exp 0/1", out_valid64, zero64); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        drive(7'b0110011, 3'b000, 7'b0000000, 32'd7, 32'hFFFF_FFFD);
        checks++; if (out_valid !== 1'b1 || alu_out !== 32'd4 || zero !== 1'b0) begin failures++; $display("FAIL add_7_m3 valid=%b out=%h zero=%b exp 1/00000004/0", out_valid, alu_out, zero); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        drive(7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd5);
        checks++; if (out_valid !== 1'b1 || alu_out !== 32'd0 || zero !== 1'b1) begin failures++; $display("FAIL sub_5_5 valid=%b out=%h zero=%b exp 1/00000000/1", out_valid, alu_out, zero); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_single_cycle();
        sc_vec_t v[16];
        v[0]  = '{7'b0110011, 3'b001, 7'b0000000, 32'h0000_0001, 32'd33,        32'h0000_0002}; // SLL uses shamt[4:0]
        v[1]  = '{7'b0110011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4,         32'hF800_0000}; // SRA
        v[2]  = '{7'b0110011, 3'b101, 7'b0000000, 32'h8000_0000, 32'd4,         32'h0800_0000}; // SRL
        v[3]  = '{7'b0110011, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001}; // SLT
        v[4]  = '{7'b0110011, 3'b011, 7'b0000000, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000}; // SLTU
        v[5]  = '{7'b1100011, 3'b100, 7'b0000000, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001}; // BLT
        v[6]  = '{7'b1100011, 3'b111, 7'b0000000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000}; // BGEU
        v[7]  = '{7'b1100011, 3'b010, 7'b0000000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000}; // undefined branch
        v[8]  = '{7'b0000011, 3'b010, 7'b0000000, 32'h0000_1000, 32'h0000_0024, 32'h0000_1024}; // LW address
        v[9]  = '{7'b0100011, 3'b100, 7'b0000000, 32'h0000_1000, 32'h0000_0024, 32'h0000_0000}; // undefined store
        v[10] = '{7'b0110111, 3'b000, 7'b0000000, 32'h0000_0000, 32'h1234_5678, 32'h1234_5000}; // LUI
        v[11] = '{7'b0010111, 3'b000, 7'b0000000, 32'h0000_1000, 32'h0000_2ABC, 32'h0000_3000}; // AUIPC
        v[12] = '{7'b1101111, 3'b000, 7'b0000000, 32'h0000_0100, 32'h0000_0040, 32'h0000_0104}; // JAL
        v[13] = '{7'b0110011, 3'b000, 7'b0000010, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000}; // bad func7
        v[14] = '{7'b0010011, 3'b101, 7'b0100000, 32'hF000_0000, 32'd8,         32'hFFF0_0000}; // SRAI
        v[15] = '{7'b1111111, 3'b000, 7'b0000000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000}; // bad opcode
        for (int i = 0; i < 16; i++) begin
            drive(v[i].op, v[i].f3, v[i].f7, v[i].a, v[i].b);
            checks++;
            if (out_valid !== 1'b1 || alu_out !== v[i].exp || zero !== (v[i].exp == 32'h0)) begin
                failures++;
                $display("FAIL single_cycle[%0d] valid=%b out=%h zero=%b exp_out=%h", i, out_valid, alu_out, zero, v[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_muldiv();
        m_vec_t v[11];
        int     cyc;
        bit     stall_bad;
        v[0]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32}; // MULH
        v[1]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32}; // MULHSU
        v[2]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 32}; // MUL 7*-3
        v[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32}; // MULHU
        v[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32}; // DIV -7/2
        v[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32}; // REM -7/2
        v[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        32}; // DIVU
        v[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         32}; // REMU
        v[8]  = '{3'b101, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 0};  // DIVU by 0
        v[9]  = '{3'b110, 32'd5,         32'd0,         32'd5,         0};  // REM by 0
        v[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};  // DIV overflow
        for (int i = 0; i < 11; i++) begin
            drive(7'b0110011, v[i].f3, 7'b0000001, v[i].a, v[i].b);
            wait_out(100, cyc, stall_bad);
            checks++;
            if (out_valid !== 1'b1 || cyc != v[i].lat || stall_bad) begin
                failures++;
                $display("FAIL muldiv_latency[%0d] valid=%b cycles=%0d exp_cycles=%0d stall_bad=%0d", i, out_valid, cyc, v[i].lat, stall_bad);
            end
            checks++;
            if (alu_out !== v[i].exp || zero !== (v[i].exp == 32'h0)) begin
                failures++;
                $display("FAIL muldiv_result[%0d] out=%h zero=%b exp=%h", i, alu_out, zero, v[i].exp);
            end
            @(posedge clk); #1;
        end
        // REM overflow gives zero and sets the zero flag
        drive(7'b0110011, 3'b110, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (out_valid !== 1'b1 || alu_out !== 32'h0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL rem_overflow valid=%b out=%h zero=%b exp 1/00000000/1", out_valid, alu_out, zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(7'b0110011, 3'b011, 7'b0000000, 32'd1, 32'd2);
        for (int i = 0; i < 5; i++) begin
            opcode = 7'b0110011; func3 = 3'b000; func7 = 7'b0000000; op1 = 32'd9; op2 = 32'd9;
            in_valid = 1'b1;
            checks++;
            if (out_valid !== 1'b1 || alu_out !== 32'd1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure[%0d] valid=%b out=%h in_ready=%b exp 1/00000001/0", i, out_valid, alu_out, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_out !== 32'd1) begin
            failures++;
            $display("FAIL backpressure_hold valid=%b out=%h exp 1/00000001", out_valid, alu_out);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release out_valid=%b exp=0", out_valid);
        end
    endtask

    task automatic test_flush();
        bit seen;
        drive(7'b0110011, 3'b101, 7'b0000001, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        opcode = 7'b0110011; func3 = 3'b000; func7 = 7'b0000000; op1 = 32'd1; op2 = 32'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_state valid=%b busy=%b in_ready=%b exp 0/0/1", out_valid, busy, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL flush_discard out_valid_seen=%0d exp=0", seen);
        end
        drive(7'b0010011, 3'b111, 7'b0000000, 32'h0000_00F0, 32'h0000_003C);
        checks++;
        if (out_valid !== 1'b1 || alu_out !== 32'h30) begin
            failures++;
            $display("FAIL andi_after_flush valid=%b out=%h exp 1/00000030", out_valid, alu_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_xlen64();
        int cyc;
        drive64(7'b0110011, 3'b000, 7'b0000100, 64'd3, 64'd4);
        checks++;
        if (out_valid64 !== 1'b1 || alu_out64 !== 64'h0 || zero64 !== 1'b1) begin
            failures++;
            $display("FAIL x64_bad_func7 valid=%b out=%h zero=%b exp 1/0/1", out_valid64, alu_out64, zero64);
        end
        @(posedge clk); #1;
        drive64(7'b0110011, 3'b101, 7'b0100000, 64'h8000_0000_0000_0000, 64'd63);
        checks++;
        if (out_valid64 !== 1'b1 || alu_out64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL x64_sra valid=%b out=%h exp all-ones", out_valid64, alu_out64);
        end
        @(posedge clk); #1;
        drive64(7'b0110011, 3'b000, 7'b0000001, 64'h0000_0001_0000_0000, 64'd3);
        wait_out64(200, cyc);
        checks++;
        if (out_valid64 !== 1'b1 || cyc != 64 || alu_out64 !== 64'h0000_0003_0000_0000) begin
            failures++;
            $display("FAIL x64_mul valid=%b cycles=%0d out=%h exp 1/64/0000000300000000", out_valid64, cyc, alu_out64);
        end
        @(posedge clk); #1;
        drive64(7'b0110011, 3'b000, 7'b0000001, 64'd5, 64'd5);
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (busy64 !== 1'b1) begin
            failures++;
            $display("FAIL x64_mid_mul_busy got=%b exp=1", busy64);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid64 !== 1'b0 || busy64 !== 1'b0 || alu_out64 !== 64'h0 || zero64 !== 1'b1) begin
            failures++;
            $display("FAIL x64_rst_mid_mul valid=%b busy=%b out=%h zero=%b exp 0/0/0/1", out_valid64, busy64, alu_out64, zero64);
        end
        cyc = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid64) cyc++;
            @(posedge clk); #1;
        end
        checks++;
        if (cyc != 0) begin
            failures++;
            $display("FAIL x64_rst_no_result valid_cycles=%0d exp=0", cyc);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; func3 = '0; func7 = '0; op1 = '0; op2 = '0;
        flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b1;
        opcode64 = '0; func3_64 = '0; func7_64 = '0; op1_64 = '0; op2_64 = '0;
        test_reset();
        test_back_to_back();
        test_single_cycle();
        test_muldiv();
        test_backpressure();
        test_flush();
        test_xlen64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
